// File: rtl/mem_port_arbiter.sv
// Shares the single core memory port between fetch reads, load reads and the committed-store FIFO drain.
// Committed stores always go ahead of loads; a pipeline flush cancels outstanding speculative reads.
module mem_port_arbiter #(
  parameter bit          FETCH_ALWAYS_WINS = 1'b0,
  parameter int unsigned MEM_TIMEOUT       = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_pipeline_flush,
  input  logic        i_fetch_req,
  input  logic [31:0] i_fetch_addr,
  output logic        o_fetch_ack,
  output logic [31:0] o_fetch_data,
  input  logic        i_load_req,
  input  logic [31:0] i_load_addr,
  input  logic [1:0]  i_load_size,
  output logic        o_load_ack,
  output logic [31:0] o_load_data,
  input  logic        i_store_empty,
  input  logic [31:0] i_store_addr,
  input  logic [31:0] i_store_val,
  input  logic [1:0]  i_store_size,
  output logic        o_store_pop,
  output logic        o_mem_valid,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [1:0]  o_mem_size,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_rdata,
  output logic        o_bus_error,
  output logic        o_dbg_state,
  output logic [1:0]  o_dbg_owner
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;
  typedef enum logic [1:0] {OWN_FETCH = 2'd0, OWN_LOAD = 2'd1, OWN_STORE = 2'd2} owner_t;

  localparam bit          TIMEOUT_EN  = (MEM_TIMEOUT != 0);
  localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);

  state_t      r_state, w_state_next;
  owner_t      r_owner;
  logic        r_last_was_fetch;
  logic        r_cancel;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_we;
  logic [15:0] r_count;

  logic w_fetch_cand, w_store_cand, w_load_cand, w_data_cand;
  logic w_pick_fetch, w_grant, w_busy, w_timeout, w_done, w_finish, w_read_suppress;

  assign w_fetch_cand = i_fetch_req && !i_pipeline_flush;
  assign w_store_cand = !i_store_empty;
  assign w_load_cand  = i_load_req && !i_pipeline_flush;
  assign w_data_cand  = w_store_cand || w_load_cand;
  // Round-robin gives the data side the next slot only right after a fetch grant.
  assign w_pick_fetch = w_fetch_cand && (!w_data_cand || FETCH_ALWAYS_WINS || !r_last_was_fetch);
  assign w_grant      = (r_state == S_IDLE) && (w_fetch_cand || w_data_cand);

  assign w_busy    = (r_state == S_BUSY);
  assign w_timeout = TIMEOUT_EN && w_busy && (r_count == TIMEOUT_VAL);
  assign w_done    = w_busy && !w_timeout && i_mem_ready;
  assign w_finish  = w_done || w_timeout;
  // A flush on the completion cycle itself also swallows the read ack.
  assign w_read_suppress = r_cancel || i_pipeline_flush || reset;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    o_mem_valid  = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = 32'd0;
    o_mem_wdata  = 32'd0;
    o_mem_size   = 2'd0;
    o_fetch_ack  = 1'b0;
    o_fetch_data = 32'd0;
    o_load_ack   = 1'b0;
    o_load_data  = 32'd0;
    o_store_pop  = 1'b0;
    o_bus_error  = 1'b0;
    case (r_state)
      S_IDLE: if (w_grant) w_state_next = S_BUSY;
      S_BUSY: begin
        if (w_finish) w_state_next = S_IDLE;
        o_mem_valid = !w_timeout;
        if (o_mem_valid) begin
          o_mem_we    = r_we;
          o_mem_addr  = r_addr;
          o_mem_wdata = r_wdata;
          o_mem_size  = r_size;
        end
        o_bus_error = w_timeout && !reset;
        if (w_finish) begin
          case (r_owner)
            OWN_FETCH: begin
              o_fetch_ack  = !w_read_suppress;
              o_fetch_data = (o_fetch_ack && w_done) ? i_mem_rdata : 32'd0;
            end
            OWN_LOAD: begin
              o_load_ack  = !w_read_suppress;
              o_load_data = (o_load_ack && w_done) ? i_mem_rdata : 32'd0;
            end
            default: o_store_pop = !reset;
          endcase
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_owner          <= OWN_FETCH;
      r_last_was_fetch <= 1'b0;
      r_cancel         <= 1'b0;
      r_addr           <= 32'd0;
      r_wdata          <= 32'd0;
      r_size           <= 2'd0;
      r_we             <= 1'b0;
      r_count          <= 16'd0;
    end else if (w_grant) begin
      r_last_was_fetch <= w_pick_fetch;
      r_cancel         <= 1'b0;
      r_count          <= 16'd0;
      if (w_pick_fetch) begin
        r_owner <= OWN_FETCH;
        r_addr  <= i_fetch_addr;
        r_wdata <= 32'd0;
        r_size  <= 2'd2;
        r_we    <= 1'b0;
      end else if (w_store_cand) begin
        r_owner <= OWN_STORE;
        r_addr  <= i_store_addr;
        r_wdata <= i_store_val;
        r_size  <= i_store_size;
        r_we    <= 1'b1;
      end else begin
        r_owner <= OWN_LOAD;
        r_addr  <= i_load_addr;
        r_wdata <= 32'd0;
        r_size  <= i_load_size;
        r_we    <= 1'b0;
      end
    end else if (w_busy) begin
      if (i_pipeline_flush && r_owner != OWN_STORE) r_cancel <= 1'b1;
      if (TIMEOUT_EN && !i_mem_ready && !w_timeout) r_count <= r_count + 16'd1;
    end
  end

  assign o_dbg_state = r_state;
  assign o_dbg_owner = r_owner;

  // Requesters must hold a read request until its ack unless a flush cancelled it.
  a_req_held: assert property (@(posedge clk) disable iff (reset)
    (w_busy && !r_cancel && !i_pipeline_flush && r_owner != OWN_STORE) |->
    ((r_owner == OWN_FETCH) ? i_fetch_req : i_load_req));

endmodule
